mpu_regfile_ctrl: RTL and testbench

- Sequencer for the MPU matrix register file. Accepts matrix load commands and a row-major element stream, and drives the file's write port (write_en, load address, row/column indices, element).
- Accepts matrix store (read-out) commands. Drives reg_store_addr and flags the cycle in which the file's registered matrix_out holds the requested matrix.
- Blocks a store from a register that is still being loaded. Sits between the MPU command/data front end and the register file.

---
 rtl/mpu_regfile_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mpu_regfile_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_regfile_ctrl.sv
// Load/store sequencer for the MPU matrix register file: turns load commands plus a
// row-major element stream into write-port traffic, and sequences hazard-checked read-outs.
module mpu_regfile_ctrl #(
    parameter int FP               = 32,
    parameter int M                = 4,
    parameter int N                = 4,
    parameter int MBITS            = 2,
    parameter int NBITS            = 2,
    parameter int MATRIX_REGISTERS = 8,
    parameter int MATRIX_REG_SIZE  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_req,
    output logic                       ld_ready,
    input  logic [MATRIX_REG_SIZE-1:0] ld_addr,
    input  logic [MBITS:0]             ld_rows,
    input  logic [NBITS:0]             ld_cols,
    input  logic                       elem_valid,
    output logic                       elem_ready,
    input  logic [FP-1:0]              elem_data,
    output logic                       ld_done,
    output logic                       ld_err,
    input  logic                       st_req,
    output logic                       st_ready,
    input  logic [MATRIX_REG_SIZE-1:0] st_addr,
    output logic                       st_valid,
    output logic                       write_en,
    output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
    output logic [FP-1:0]              reg_element_in,
    output logic [MBITS:0]             reg_m_in,
    output logic [NBITS:0]             reg_n_in,
    output logic [MATRIX_REG_SIZE-1:0] reg_store_addr
);

    typedef enum logic [1:0] {L_IDLE, L_STREAM, L_DONE} lstate_t;
    typedef enum logic [1:0] {S_IDLE, S_HAZ, S_ADDR, S_VALID} sstate_t;

    localparam logic [MBITS:0] ROW_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] COL_MAX = (NBITS+1)'(N);
    localparam logic [MBITS:0] ROW_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] COL_ONE = (NBITS+1)'(1);

    if (MATRIX_REGISTERS > (1 << MATRIX_REG_SIZE)) begin : g_cfg_chk
        $error("MATRIX_REGISTERS does not fit in MATRIX_REG_SIZE address bits");
    end

    lstate_t                    lstate, lstate_d;
    sstate_t                    sstate, sstate_d;
    logic [MATRIX_REG_SIZE-1:0] ld_addr_q, ld_addr_d, st_addr_q, st_addr_d;
    logic [MATRIX_REG_SIZE-1:0] load_addr_d, store_addr_d;
    logic [MBITS:0]             rows_q, rows_d, r_q, r_d, m_d;
    logic [NBITS:0]             cols_q, cols_d, c_q, c_d, n_d;
    logic [FP-1:0]              elem_d;
    logic                       we_d, done_d, err_d, stv_d;
    logic                       ld_hs, el_hs, st_hs, ld_bad, last_col, last_row, hazard;

    assign ld_ready   = (lstate == L_IDLE) && rst;
    assign elem_ready = (lstate == L_STREAM) && rst;
    assign st_ready   = (sstate == S_IDLE) && rst;

    assign ld_hs    = ld_req && ld_ready;
    assign el_hs    = elem_valid && elem_ready;
    assign st_hs    = st_req && st_ready;
    assign ld_bad   = (ld_rows == '0) || (ld_rows > ROW_MAX) || (ld_cols == '0) || (ld_cols > COL_MAX);
    assign last_col = (c_q == cols_q - COL_ONE);
    assign last_row = (r_q == rows_q - ROW_ONE);
    // A load accepted in the same cycle is not yet visible here, so the store reads pre-load data.
    assign hazard   = (lstate != L_IDLE) && (ld_addr_q == st_addr);

    always_comb begin
        lstate_d    = lstate;
        ld_addr_d   = ld_addr_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        r_d         = r_q;
        c_d         = c_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_addr_d = reg_load_addr;
        m_d         = reg_m_in;
        n_d         = reg_n_in;
        elem_d      = reg_element_in;
        case (lstate)
            L_IDLE: if (ld_hs) begin
                ld_addr_d = ld_addr;
                rows_d    = ld_rows;
                cols_d    = ld_cols;
                r_d       = '0;
                c_d       = '0;
                if (ld_bad) err_d = 1'b1;
                else        lstate_d = L_STREAM;
            end
            L_STREAM: if (el_hs) begin
                we_d        = 1'b1;
                load_addr_d = ld_addr_q;
                m_d         = r_q;
                n_d         = c_q;
                elem_d      = elem_data;
                if (last_col) begin
                    c_d = '0;
                    r_d = r_q + ROW_ONE;
                end else begin
                    c_d = c_q + COL_ONE;
                end
                if (last_col && last_row) lstate_d = L_DONE;
            end
            L_DONE: begin
                done_d   = 1'b1;
                lstate_d = L_IDLE;
            end
            default: lstate_d = L_IDLE;
        endcase
    end

    always_comb begin
        sstate_d     = sstate;
        st_addr_d    = st_addr_q;
        store_addr_d = reg_store_addr;
        stv_d        = 1'b0;
        case (sstate)
            S_IDLE: if (st_hs) begin
                st_addr_d = st_addr;
                if (hazard) begin
                    sstate_d = S_HAZ;
                end else begin
                    store_addr_d = st_addr;
                    sstate_d     = S_ADDR;
                end
            end
            S_HAZ: if (lstate == L_IDLE) begin
                store_addr_d = st_addr_q;
                sstate_d     = S_ADDR;
            end
            S_ADDR: begin
                stv_d    = 1'b1;
                sstate_d = S_VALID;
            end
            S_VALID: sstate_d = S_IDLE;
            default: sstate_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lstate         <= L_IDLE;
            sstate         <= S_IDLE;
            ld_addr_q      <= '0;
            st_addr_q      <= '0;
            rows_q         <= '0;
            cols_q         <= '0;
            r_q            <= '0;
            c_q            <= '0;
            write_en       <= 1'b0;
            reg_load_addr  <= '0;
            reg_element_in <= '0;
            reg_m_in       <= '0;
            reg_n_in       <= '0;
            reg_store_addr <= '0;
            ld_done        <= 1'b0;
            ld_err         <= 1'b0;
            st_valid       <= 1'b0;
        end else begin
            lstate         <= lstate_d;
            sstate         <= sstate_d;
            ld_addr_q      <= ld_addr_d;
            st_addr_q      <= st_addr_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            r_q            <= r_d;
            c_q            <= c_d;
            write_en       <= we_d;
            reg_load_addr  <= load_addr_d;
            reg_element_in <= elem_d;
            reg_m_in       <= m_d;
            reg_n_in       <= n_d;
            reg_store_addr <= store_addr_d;
            ld_done        <= done_d;
            ld_err         <= err_d;
            st_valid       <= stv_d;
        end
    end

endmodule

// File: tb/tb_mpu_regfile_ctrl.sv
// Scoreboard bench for mpu_regfile_ctrl: stimulus pushes expected writes/pulses/read-outs,
// a negedge monitor pops and compares them against a behavioural register file.
module tb_mpu_regfile_ctrl;

    typedef struct {
        logic [2:0]  addr;
        int          m;
        int          n;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_req = 1'b0, elem_valid = 1'b0, st_req = 1'b0;
    logic [2:0]  ld_addr = '0, ld_rows = '0, ld_cols = '0, st_addr = '0;
    logic [31:0] elem_data = '0;
    logic        ld_ready, elem_ready, ld_done, ld_err, st_ready, st_valid, write_en;
    logic [2:0]  reg_load_addr, reg_m_in, reg_n_in, reg_store_addr;
    logic [31:0] reg_element_in;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ld_last_h = 0;
    exp_t wq[$];
    exp_t sq[$];
    int   dq[$];
    int   eq[$];
    bit [31:0] rf [8][4][4];
    bit [31:0] mo [4][4];

    mpu_regfile_ctrl dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_rows(ld_rows), .ld_cols(ld_cols),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
        .ld_done(ld_done), .ld_err(ld_err),
        .st_req(st_req), .st_ready(st_ready), .st_addr(st_addr), .st_valid(st_valid),
        .write_en(write_en), .reg_load_addr(reg_load_addr), .reg_element_in(reg_element_in),
        .reg_m_in(reg_m_in), .reg_n_in(reg_n_in), .reg_store_addr(reg_store_addr)
    );

    always #5 clk = ~clk;

    // Register file model: write port plus registered matrix_out.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_en) rf[reg_load_addr][reg_m_in[1:0]][reg_n_in[1:0]] <= reg_element_in;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mo[i][j] <= rf[reg_store_addr][i][j];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_load(input logic [2:0] a, input logic [2:0] rows, input logic [2:0] cols,
                           input logic [31:0] base, input bit gap, input int stop_after);
        int   n;
        int   h;
        int   nc;
        exp_t e;
        ld_req = 1'b1; ld_addr = a; ld_rows = rows; ld_cols = cols;
        n = 0;
        while (!ld_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ld_accept", ld_ready, 1);
        h = cyc;
        @(posedge clk); #1;
        ld_req = 1'b0;
        if (rows == 0 || rows > 4 || cols == 0 || cols > 4) begin
            eq.push_back(h + 1);
            return;
        end
        nc = int'(cols);
        for (int k = 0; k < int'(rows) * nc; k++) begin
            if (gap && k > 0) begin elem_valid = 1'b0; @(posedge clk); #1; end
            elem_valid = 1'b1;
            elem_data  = base + k;
            n = 0;
            while (!elem_ready && n < 50) begin @(posedge clk); #1; n++; end
            chk("elem_accept", elem_ready, 1);
            h = cyc;
            e.addr = a; e.m = k / nc; e.n = k % nc; e.data = base + k; e.cyc = h + 1;
            wq.push_back(e);
            @(posedge clk); #1;
            if (k + 1 == stop_after) begin elem_valid = 1'b0; return; end
        end
        elem_valid = 1'b0;
        ld_last_h  = h;
        dq.push_back(h + 2);
    endtask

    task automatic do_store(input logic [2:0] a, input int r, input int c,
                            input logic [31:0] v, input bit haz);
        int   n;
        exp_t e;
        st_req = 1'b1; st_addr = a;
        n = 0;
        while (!st_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("st_accept", st_ready, 1);
        e.addr = a; e.m = r; e.n = c; e.data = v; e.cyc = haz ? -2 : cyc + 2;
        sq.push_back(e);
        @(posedge clk); #1;
        st_req = 1'b0;
        if (!haz) chk("st_addr_early", reg_store_addr, a);
    endtask

    // Monitor: every DUT output event must match the head of its queue.
    initial begin
        exp_t e;
        int   ec;
        forever begin
            @(negedge clk);
            if (write_en) begin
                if (wq.size() == 0) chk("write_unexpected", write_en, 0);
                else begin
                    e = wq.pop_front();
                    chk("write", {reg_load_addr, reg_m_in, reg_n_in, reg_element_in},
                        {e.addr, 3'(e.m), 3'(e.n), e.data});
                    chk("write_cyc", cyc, e.cyc);
                end
            end
            if (ld_done) begin
                if (dq.size() == 0) chk("done_unexpected", ld_done, 0);
                else chk("done_cyc", cyc, dq.pop_front());
            end
            if (ld_err) begin
                if (eq.size() == 0) chk("err_unexpected", ld_err, 0);
                else chk("err_cyc", cyc, eq.pop_front());
            end
            if (st_valid) begin
                if (sq.size() == 0) chk("stv_unexpected", st_valid, 0);
                else begin
                    e  = sq.pop_front();
                    ec = (e.cyc == -2) ? ld_last_h + 4 : e.cyc;
                    chk("st_addr", reg_store_addr, e.addr);
                    chk("st_data", mo[e.m][e.n], e.data);
                    chk("st_cyc", cyc, ec);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {write_en, ld_done, ld_err, st_valid, reg_load_addr, reg_m_in, reg_n_in,
                           reg_element_in, reg_store_addr}, 0);
        chk("reset_readies", {ld_ready, elem_ready, st_ready}, 3'b000);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", {ld_ready, elem_ready, st_ready}, 3'b101);

        do_load(3'd5, 3'd2, 3'd3, 32'd1, 1'b0, 0);         // 2x3 back to back
        do_load(3'd6, 3'd3, 3'd3, 32'h10, 1'b1, 0);        // 3x3 with bubbles
        do_load(3'd1, 3'd0, 3'd2, 32'd0, 1'b0, 0);         // rows = 0
        chk("ld_ready_after_err0", ld_ready, 1);
        do_load(3'd1, 3'd2, 3'd5, 32'd0, 1'b0, 0);         // cols = N+1
        chk("ld_ready_after_err1", ld_ready, 1);
        do_load(3'd7, 3'd4, 3'd4, 32'd500, 1'b0, 0);       // full M x N
        do_load(3'd2, 3'd1, 3'd1, 32'hABCD, 1'b0, 0);      // 1x1
        repeat (3) @(posedge clk);
        #1;
        do_store(3'd2, 0, 0, 32'hABCD, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        do_store(3'd7, 3, 3, 32'd515, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Store to reg 5 while it is being reloaded: must wait and return the new last element.
        fork
            do_load(3'd5, 3'd3, 3'd3, 32'd101, 1'b0, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                do_store(3'd5, 2, 2, 32'd109, 1'b1);
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Reset after 4 of 9 elements.
        do_load(3'd3, 3'd3, 3'd3, 32'd200, 1'b0, 4);
        rst = 1'b0;
        #1;
        chk("elem_ready_in_rst", elem_ready, 0);
        chk("ld_ready_in_rst", ld_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_outs", {write_en, ld_done, ld_err, st_valid, reg_load_addr, reg_m_in, reg_n_in,
                              reg_element_in, reg_store_addr}, 0);
        chk("post_rst_readies", {ld_ready, elem_ready, st_ready}, 3'b101);
        repeat (3) @(posedge clk);
        #1;
        do_load(3'd3, 3'd2, 3'd2, 32'd300, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        do_store(3'd3, 1, 1, 32'd303, 1'b0);
        repeat (8) @(posedge clk);
        #1;

        chk("write_q_drained", wq.size(), 0);
        chk("done_q_drained", dq.size(), 0);
        chk("err_q_drained", eq.size(), 0);
        chk("store_q_drained", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
